// File: rtl/keypoint_out_stream.sv
// keypoint_out_stream: serialises layer-1/layer-2 keypoint memories onto a 16-bit valid/ready stream
// Two count headers first, then {layer, row} / {col} word pairs per entry.
module keypoint_out_stream #(
  parameter int KP_AW = 12,
  parameter int KP_DW = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KP_AW:0]   kp1_count,
  input  logic [KP_AW:0]   kp2_count,
  output logic             kp1_rd_en,
  output logic [KP_AW-1:0] kp1_addr,
  input  logic [KP_DW-1:0] kp1_rdata,
  output logic             kp2_rd_en,
  output logic [KP_AW-1:0] kp2_addr,
  input  logic [KP_DW-1:0] kp2_rdata,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             stream_done
);
  typedef enum logic [2:0] {IDLE, HDR1, HDR2, RD, CAP, W0, W1, DONE} state_t;
  localparam logic [KP_AW:0] MAX_CNT = {1'b1, {KP_AW{1'b0}}};
  state_t             state_q, state_d;
  logic [KP_AW:0]     c1_q, c1_d, c2_q, c2_d, idx_q, idx_d, idx_nx, cur_c;
  logic               l2_q, l2_d, xfer, rd_en;
  logic [KP_AW-1:0]   rd_idx;
  logic [KP_DW-1:0]   hold_q, hold_d;
  assign out_valid   = state_q == HDR1 || state_q == HDR2 || state_q == W0 || state_q == W1;
  assign xfer        = out_valid && out_ready;
  assign stream_done = state_q == DONE;
  assign cur_c       = l2_q ? c2_q : c1_q;
  assign idx_nx      = idx_q + 1'b1;
  assign kp1_rd_en   = rd_en && !l2_q;
  assign kp2_rd_en   = rd_en && l2_q;
  assign kp1_addr    = kp1_rd_en ? rd_idx : '0;
  assign kp2_addr    = kp2_rd_en ? rd_idx : '0;
  always_comb begin
    state_d  = state_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    idx_d    = idx_q;
    l2_d     = l2_q;
    hold_d   = hold_q;
    rd_en    = 1'b0;
    rd_idx   = idx_q[KP_AW-1:0];
    out_data = '0;
    case (state_q)
      IDLE: if (start) begin
        c1_d    = kp1_count > MAX_CNT ? MAX_CNT : kp1_count;
        c2_d    = kp2_count > MAX_CNT ? MAX_CNT : kp2_count;
        state_d = HDR1;
      end
      HDR1: begin
        out_data = {{(15-KP_AW){1'b0}}, c1_q};
        state_d  = xfer ? HDR2 : HDR1;
      end
      HDR2: begin
        out_data = {{(15-KP_AW){1'b0}}, c2_q};
        if (xfer) begin
          idx_d   = '0;
          l2_d    = c1_q == '0;
          state_d = (c1_q != '0 || c2_q != '0) ? RD : DONE;
        end
      end
      RD: begin
        rd_en   = 1'b1;
        state_d = CAP;
      end
      CAP: begin
        hold_d  = l2_q ? kp2_rdata : kp1_rdata;
        state_d = W0;
      end
      W0: begin
        out_data = {l2_q, 6'b0, hold_q[18:10]};
        state_d  = xfer ? W1 : W0;
      end
      W1: begin
        out_data = {6'b0, hold_q[9:0]};
        // next entry's read overlaps this word's transfer to sustain 3 cycles per entry
        if (xfer) begin
          if (idx_nx < cur_c) begin
            idx_d   = idx_nx;
            rd_en   = 1'b1;
            rd_idx  = idx_nx[KP_AW-1:0];
            state_d = CAP;
          end else if (!l2_q && c2_q != '0) begin
            l2_d    = 1'b1;
            idx_d   = '0;
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c1_q    <= '0;
      c2_q    <= '0;
      idx_q   <= '0;
      l2_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      idx_q   <= idx_d;
      l2_q    <= l2_d;
      hold_q  <= hold_d;
    end
  end
endmodule
